mpt_plb_cache: RTL and testbench

- Parametrised, fully-associative Protection Lookaside Buffer (PLB) for the MPT checker.
- Caches per-page permissions for the tag {SDID, SPA page number} and serves single-cycle-latency lookups ahead of the MPT walker.
- The walker fills the buffer on a miss.
- Supports two flush modes: flush-all in one cycle, and flush-by-SDID as a multi-cycle sweep.

---
 rtl/mpt_plb_cache.sv | 229 ++++++++++++++++++++++
 tb/tb_mpt_plb_cache.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpt_plb_cache.sv
// mpt_plb_cache: fully-associative Protection Lookaside Buffer for the MPT
// checker. Caches {SDID, page number} -> {X,W,R} permissions and answers
// lookups with a registered response one cycle after acceptance. The walker
// refills it on a miss. Flushes clear everything in one cycle, or sweep the
// entries one per cycle and clear those belonging to a single SDID.
module mpt_plb_cache #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned SDID_LEN      = 6,
  parameter int unsigned NUM_ENTRIES   = 8,
  parameter int unsigned PAGE_OFFSET_W = 12,
  parameter int unsigned PERM_W        = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // lookup request
  input  logic                lkp_valid_i,
  output logic                lkp_ready_o,
  input  logic [SDID_LEN-1:0] lkp_sdid_i,
  input  logic [XLEN-1:0]     lkp_spa_i,
  input  logic [1:0]          lkp_access_i,
  // lookup response
  output logic                rsp_valid_o,
  output logic                rsp_hit_o,
  output logic [PERM_W-1:0]   rsp_perms_o,
  output logic                rsp_allowed_o,
  // walker fill
  input  logic                fill_valid_i,
  input  logic [SDID_LEN-1:0] fill_sdid_i,
  input  logic [XLEN-1:0]     fill_spa_i,
  input  logic [PERM_W-1:0]   fill_perms_i,
  // flush control
  input  logic                flush_i,
  input  logic                flush_all_i,
  input  logic [SDID_LEN-1:0] flush_sdid_i,
  output logic                flush_busy_o
);

  localparam int unsigned PN_W  = XLEN - PAGE_OFFSET_W;
  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  typedef logic [IDX_W-1:0] idx_t;

  // Entry storage: valid bits are control state, the rest is plain data.
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [SDID_LEN-1:0]    sdid_q  [NUM_ENTRIES];
  logic [PN_W-1:0]        pn_q    [NUM_ENTRIES];
  logic [PERM_W-1:0]      perms_q [NUM_ENTRIES];

  state_t              state_q, state_d;
  idx_t                sweep_idx_q, sweep_idx_d;
  idx_t                victim_q, victim_d;
  logic [SDID_LEN-1:0] flush_sdid_q;
  logic                sweep_start;

  // Write port into the entry array (driven by the control process).
  logic                wr_en;
  logic                wr_alloc;
  idx_t                wr_idx;

  // Page numbers of the two incoming addresses; offsets do not take part.
  logic [PN_W-1:0] lkp_pn, fill_pn;
  assign lkp_pn  = lkp_spa_i[XLEN-1:PAGE_OFFSET_W];
  assign fill_pn = fill_spa_i[XLEN-1:PAGE_OFFSET_W];

  logic unused_offset_bits;
  assign unused_offset_bits = ^{lkp_spa_i[PAGE_OFFSET_W-1:0],
                                fill_spa_i[PAGE_OFFSET_W-1:0]};

  // Handshake: lookups only in IDLE and only when nothing higher-priority
  // is using the array this cycle.
  logic lkp_accept;
  assign lkp_ready_o  = rst_ni & (state_q == IDLE) & ~flush_i & ~fill_valid_i;
  assign lkp_accept   = lkp_valid_i & lkp_ready_o;
  assign flush_busy_o = (state_q == SWEEP);

  // Lookup tag match across all valid entries. At most one entry can match,
  // so OR-ing the matching permissions yields the single hit's permissions.
  logic              lkp_hit;
  logic [PERM_W-1:0] lkp_perms;
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    lkp_hit   = 1'b0;
    lkp_perms = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && sdid_q[i] == lkp_sdid_i && pn_q[i] == lkp_pn) begin
        lkp_hit   = 1'b1;
        lkp_perms = lkp_perms | perms_q[i];
      end
    end
  end

  // Access check against the {X,W,R} permission bits; "none" never passes.
  logic perm_ok, lkp_allowed;
  always_comb begin
    perm_ok = 1'b0;
    case (lkp_access_i)
      2'b01:   perm_ok = lkp_perms[0];
      2'b10:   perm_ok = lkp_perms[1];
      2'b11:   perm_ok = lkp_perms[2];
      default: perm_ok = 1'b0;
    endcase
  end
  assign lkp_allowed = lkp_hit & perm_ok;

  // Fill placement: existing entry with the same tag, else lowest free slot.
  logic fill_hit, free_found;
  idx_t fill_hit_idx, free_idx;
  always_comb begin
    fill_hit     = 1'b0;
    fill_hit_idx = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && sdid_q[i] == fill_sdid_i && pn_q[i] == fill_pn) begin
        fill_hit     = 1'b1;
        fill_hit_idx = idx_t'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = idx_t'(i);
      end
    end
  end

  // Next-state logic: flush beats fill, fill beats lookup; sweep owns the array.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    victim_d    = victim_q;
    valid_d     = valid_q;
    wr_en       = 1'b0;
    wr_alloc    = 1'b0;
    wr_idx      = '0;
    sweep_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          if (flush_all_i) begin
            valid_d = '0;
          end else begin
            state_d     = SWEEP;
            sweep_idx_d = '0;
            sweep_start = 1'b1;
          end
        end else if (fill_valid_i) begin
          wr_en = 1'b1;
          if (fill_hit) begin
            wr_idx = fill_hit_idx;
          end else begin
            wr_alloc = 1'b1;
            if (free_found) begin
              wr_idx = free_idx;
            end else begin
              wr_idx   = victim_q;
              victim_d = victim_q + idx_t'(1);
            end
            valid_d[wr_idx] = 1'b1;
          end
        end
      end
      SWEEP: begin
        if (sdid_q[sweep_idx_q] == flush_sdid_q) begin
          valid_d[sweep_idx_q] = 1'b0;
        end
        sweep_idx_d = sweep_idx_q + idx_t'(1);
        if (sweep_idx_q == idx_t'(NUM_ENTRIES - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, sweep/victim pointers, valid bits, captured SDID.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      sweep_idx_q  <= '0;
      victim_q     <= '0;
      valid_q      <= '0;
      flush_sdid_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      victim_q    <= victim_d;
      valid_q     <= valid_d;
      if (sweep_start) begin
        flush_sdid_q <= flush_sdid_i;
      end
    end
  end

  // Entry payload array, written by fills only.
  // NOTE: the payload has no reset; the valid bits alone decide whether an
  // entry is meaningful, and leaving the array unreset keeps it RAM-friendly.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      perms_q[wr_idx] <= fill_perms_i;
      if (wr_alloc) begin
        sdid_q[wr_idx] <= fill_sdid_i;
        pn_q[wr_idx]   <= fill_pn;
      end
    end
  end

  // Registered lookup response: a one-cycle pulse per accepted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o   <= 1'b0;
      rsp_hit_o     <= 1'b0;
      rsp_perms_o   <= '0;
      rsp_allowed_o <= 1'b0;
    end else begin
      rsp_valid_o   <= lkp_accept;
      rsp_hit_o     <= lkp_accept & lkp_hit;
      rsp_perms_o   <= lkp_accept ? lkp_perms : '0;
      rsp_allowed_o <= lkp_accept & lkp_allowed;
    end
  end

endmodule

// File: tb/tb_mpt_plb_cache.sv
// tb_mpt_plb_cache: directed, table-driven bench for mpt_plb_cache.
// Lookup vectors carry hand-computed expectations; flush, reset and
// priority corner cases are written out as explicit sequences.
module tb_mpt_plb_cache;

  localparam int XLEN = 64;
  localparam int SDID_LEN = 6;
  localparam int NUM_ENTRIES = 8;
  localparam int PERM_W = 3;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_RD   = 2'b01;
  localparam logic [1:0] ACC_WR   = 2'b10;
  localparam logic [1:0] ACC_EX   = 2'b11;

  logic                clk;
  logic                rst_n;
  logic                lkp_valid;
  logic                lkp_ready;
  logic [SDID_LEN-1:0] lkp_sdid;
  logic [XLEN-1:0]     lkp_spa;
  logic [1:0]          lkp_access;
  logic                rsp_valid;
  logic                rsp_hit;
  logic [PERM_W-1:0]   rsp_perms;
  logic                rsp_allowed;
  logic                fill_valid;
  logic [SDID_LEN-1:0] fill_sdid;
  logic [XLEN-1:0]     fill_spa;
  logic [PERM_W-1:0]   fill_perms;
  logic                flush;
  logic                flush_all;
  logic [SDID_LEN-1:0] flush_sdid;
  logic                flush_busy;

  mpt_plb_cache #(
    .XLEN(XLEN), .SDID_LEN(SDID_LEN), .NUM_ENTRIES(NUM_ENTRIES),
    .PAGE_OFFSET_W(12), .PERM_W(PERM_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready),
    .lkp_sdid_i(lkp_sdid), .lkp_spa_i(lkp_spa), .lkp_access_i(lkp_access),
    .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit),
    .rsp_perms_o(rsp_perms), .rsp_allowed_o(rsp_allowed),
    .fill_valid_i(fill_valid), .fill_sdid_i(fill_sdid),
    .fill_spa_i(fill_spa), .fill_perms_i(fill_perms),
    .flush_i(flush), .flush_all_i(flush_all), .flush_sdid_i(flush_sdid),
    .flush_busy_o(flush_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SDID_LEN-1:0] sdid;
    logic [XLEN-1:0]     spa;
    logic [1:0]          acc;
    logic                hit;
    logic [PERM_W-1:0]   perms;
    logic                allowed;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [SDID_LEN-1:0] sdid, input logic [XLEN-1:0] spa,
                     input logic [1:0] acc, input logic hit,
                     input logic [PERM_W-1:0] perms, input logic allowed);
    vec_t v;
    v.sdid = sdid; v.spa = spa; v.acc = acc;
    v.hit = hit; v.perms = perms; v.allowed = allowed;
    vecs.push_back(v);
  endtask

  // Back-to-back lookups of vecs[lo..hi]; entered and left at a negedge.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      lkp_valid  = 1'b1;
      lkp_sdid   = vecs[i].sdid;
      lkp_spa    = vecs[i].spa;
      lkp_access = vecs[i].acc;
      #1;
      check($sformatf("vec%0d ready", i), 64'(lkp_ready), 64'd1);
      @(negedge clk);
      check($sformatf("vec%0d rsp_valid", i), 64'(rsp_valid), 64'd1);
      check($sformatf("vec%0d hit", i), 64'(rsp_hit), 64'(vecs[i].hit));
      check($sformatf("vec%0d perms", i), 64'(rsp_perms), 64'(vecs[i].perms));
      check($sformatf("vec%0d allowed", i), 64'(rsp_allowed), 64'(vecs[i].allowed));
    end
    lkp_valid  = 1'b0;
    lkp_access = ACC_NONE;
    @(negedge clk);
    check($sformatf("vec%0d rsp pulse end", hi), 64'(rsp_valid), 64'd0);
  endtask

  task automatic do_fill(input logic [SDID_LEN-1:0] sdid, input logic [XLEN-1:0] spa,
                         input logic [PERM_W-1:0] perms);
    fill_valid = 1'b1;
    fill_sdid  = sdid;
    fill_spa   = spa;
    fill_perms = perms;
    #1;
    check("ready low during fill", 64'(lkp_ready), 64'd0);
    @(negedge clk);
    fill_valid = 1'b0;
  endtask

  task automatic do_flush_all();
    flush     = 1'b1;
    flush_all = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    flush_all = 1'b0;
  endtask

  initial begin
    // Vector table with hand-derived expectations.
    // Phase A: single page SDID=1, 0x4000_1000, perms R only.
    add(6'd1, 64'h4000_1234, ACC_RD,   1'b0, 3'b000, 1'b0); // 0: before fill
    add(6'd1, 64'h4000_1234, ACC_RD,   1'b1, 3'b001, 1'b1); // 1
    add(6'd1, 64'h4000_1FFF, ACC_WR,   1'b1, 3'b001, 1'b0); // 2
    add(6'd1, 64'h4000_1000, ACC_NONE, 1'b1, 3'b001, 1'b0); // 3
    add(6'd1, 64'h4000_1000, ACC_EX,   1'b1, 3'b001, 1'b0); // 4
    add(6'd2, 64'h4000_1000, ACC_RD,   1'b0, 3'b000, 1'b0); // 5: other SDID
    add(6'd1, 64'h4000_2000, ACC_RD,   1'b0, 3'b000, 1'b0); // 6: next page
    // Phase B: SDID=2 pages k*0x1000, k=0..9, perms = k[2:0].
    add(6'd2, 64'h0000, ACC_RD, 1'b0, 3'b000, 1'b0);        // 7: evicted
    add(6'd2, 64'h1000, ACC_RD, 1'b0, 3'b000, 1'b0);        // 8: evicted
    add(6'd2, 64'h2000, ACC_WR, 1'b1, 3'b010, 1'b1);        // 9
    add(6'd2, 64'h3000, ACC_RD, 1'b1, 3'b011, 1'b1);        // 10
    add(6'd2, 64'h4000, ACC_EX, 1'b1, 3'b100, 1'b1);        // 11
    add(6'd2, 64'h5000, ACC_WR, 1'b1, 3'b101, 1'b0);        // 12
    add(6'd2, 64'h6000, ACC_RD, 1'b1, 3'b110, 1'b0);        // 13
    add(6'd2, 64'h7000, ACC_EX, 1'b1, 3'b111, 1'b1);        // 14
    add(6'd2, 64'h8000, ACC_RD, 1'b1, 3'b000, 1'b0);        // 15
    add(6'd2, 64'h9000, ACC_RD, 1'b1, 3'b001, 1'b1);        // 16
    // Phase B2: page 3 refilled 111 in place, then page 10 evicts victim 2.
    add(6'd2, 64'h3000, ACC_WR, 1'b1, 3'b111, 1'b1);        // 17
    add(6'd2, 64'h2000, ACC_RD, 1'b0, 3'b000, 1'b0);        // 18
    add(6'd2, 64'hA000, ACC_RD, 1'b1, 3'b001, 1'b1);        // 19
    add(6'd2, 64'h4000, ACC_EX, 1'b1, 3'b100, 1'b1);        // 20
    add(6'd2, 64'h9000, ACC_RD, 1'b1, 3'b001, 1'b1);        // 21
    add(6'd2, 64'h8123, ACC_RD, 1'b1, 3'b000, 1'b0);        // 22
    // Phase C: after SDID=3 sweep (SDID=4 perms 011 survives).
    add(6'd3, 64'h3000_0000, ACC_RD, 1'b0, 3'b000, 1'b0);   // 23
    add(6'd3, 64'h3000_3000, ACC_RD, 1'b0, 3'b000, 1'b0);   // 24
    add(6'd4, 64'h3000_0000, ACC_RD, 1'b1, 3'b011, 1'b1);   // 25
    add(6'd4, 64'h3000_3000, ACC_WR, 1'b1, 3'b011, 1'b1);   // 26
    add(6'd4, 64'h3000_2000, ACC_EX, 1'b1, 3'b011, 1'b0);   // 27
    add(6'd5, 64'h5000_0000, ACC_RD, 1'b0, 3'b000, 1'b0);   // 28: dropped fill
    // Phase D: after flush-all concurrent with fill and lookup.
    add(6'd4, 64'h3000_0000, ACC_RD, 1'b0, 3'b000, 1'b0);   // 29
    add(6'd6, 64'h6000_0000, ACC_RD, 1'b0, 3'b000, 1'b0);   // 30
    // Phase E: after reset in the middle of a sweep.
    add(6'd9, 64'h9000_0000, ACC_RD, 1'b0, 3'b000, 1'b0);   // 31
    add(6'd9, 64'h9000_1000, ACC_RD, 1'b0, 3'b000, 1'b0);   // 32

    rst_n = 1'b0;
    lkp_valid = 1'b0; lkp_sdid = '0; lkp_spa = '0; lkp_access = ACC_NONE;
    fill_valid = 1'b0; fill_sdid = '0; fill_spa = '0; fill_perms = '0;
    flush = 1'b0; flush_all = 1'b0; flush_sdid = '0;

    // Reset state.
    #1;
    check("reset ready", 64'(lkp_ready), 64'd0);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_hit", 64'(rsp_hit), 64'd0);
    check("reset rsp_perms", 64'(rsp_perms), 64'd0);
    check("reset rsp_allowed", 64'(rsp_allowed), 64'd0);
    check("reset busy", 64'(flush_busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle ready", 64'(lkp_ready), 64'd1);

    // Phase A.
    run_vecs(0, 0);
    do_fill(6'd1, 64'h4000_1000, 3'b001);
    run_vecs(1, 6);

    // Phase B: capacity, replacement wrap, in-place refill.
    do_flush_all();
    for (int k = 0; k < NUM_ENTRIES + 2; k++) begin
      do_fill(6'd2, 64'(k) * 64'h1000, 3'(k));
    end
    run_vecs(7, 16);
    do_fill(6'd2, 64'h3000, 3'b111);
    do_fill(6'd2, 64'hA000, 3'b001);
    run_vecs(17, 22);

    // Phase C: SDID sweep.
    do_flush_all();
    for (int k = 0; k < 4; k++) do_fill(6'd3, 64'h3000_0000 + 64'(k) * 64'h1000, 3'b001);
    for (int k = 0; k < 4; k++) do_fill(6'd4, 64'h3000_0000 + 64'(k) * 64'h1000, 3'b011);
    flush = 1'b1; flush_all = 1'b0; flush_sdid = 6'd3;
    #1;
    check("ready low on flush", 64'(lkp_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    flush_sdid = 6'd4;  // must not affect a sweep already under way
    busy_cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (!flush_busy) break;
      busy_cnt++;
      check($sformatf("sweep cyc%0d ready", cyc), 64'(lkp_ready), 64'd0);
      fill_valid = (cyc == 2);
      fill_sdid  = 6'd5;
      fill_spa   = 64'h5000_0000;
      fill_perms = 3'b111;
      flush      = (cyc == 4);
      flush_all  = (cyc == 4);
      @(negedge clk);
    end
    fill_valid = 1'b0; flush = 1'b0; flush_all = 1'b0;
    check("sweep busy cycles", 64'(busy_cnt), 64'(NUM_ENTRIES));
    run_vecs(23, 28);

    // Phase D: flush-all beats a simultaneous fill and lookup.
    flush = 1'b1; flush_all = 1'b1;
    fill_valid = 1'b1; fill_sdid = 6'd6; fill_spa = 64'h6000_0000; fill_perms = 3'b111;
    lkp_valid = 1'b1; lkp_sdid = 6'd4; lkp_spa = 64'h3000_0000; lkp_access = ACC_RD;
    #1;
    check("flush+fill ready", 64'(lkp_ready), 64'd0);
    @(negedge clk);
    check("flush+fill no rsp", 64'(rsp_valid), 64'd0);
    flush = 1'b0; flush_all = 1'b0; fill_valid = 1'b0; lkp_valid = 1'b0;
    run_vecs(29, 30);

    // Phase E: reset during the 3rd cycle of a sweep.
    do_fill(6'd9, 64'h9000_0000, 3'b001);
    do_fill(6'd9, 64'h9000_1000, 3'b001);
    flush = 1'b1; flush_all = 1'b0; flush_sdid = 6'd7;
    @(negedge clk);
    flush = 1'b0;
    check("sweep started", 64'(flush_busy), 64'd1);
    repeat (2) @(negedge clk);
    check("sweep still busy", 64'(flush_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset mid-sweep busy", 64'(flush_busy), 64'd0);
    check("reset mid-sweep ready", 64'(lkp_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset busy", 64'(flush_busy), 64'd0);
    run_vecs(31, 32);

    // Phase F: reset while a response is on the outputs.
    lkp_valid = 1'b1; lkp_sdid = 6'd9; lkp_spa = 64'h9000_0000; lkp_access = ACC_RD;
    @(posedge clk);
    #1;
    check("pre-reset rsp_valid", 64'(rsp_valid), 64'd1);
    lkp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset kills rsp", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("no rsp after reset", 64'(rsp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
